// File: rtl/tx_arbiter_if.sv
// Bundles the two FWFT source read ports, the tx write port and the status
// outputs of tx_arbiter; master is the arbiter side, slave the environment side.
interface tx_arbiter_if;
  logic [8:0]  src0_dout;
  logic [8:0]  src1_dout;
  logic        src0_empty;
  logic        src1_empty;
  logic        src0_rd_en;
  logic        src1_rd_en;
  logic        tx_afull;
  logic        tx_wr_en;
  logic [8:0]  tx_wr_data;
  logic        grant;
  logic [15:0] frame_cnt;
  logic [15:0] trunc_cnt;

  modport master (
    input  src0_dout, src1_dout, src0_empty, src1_empty, tx_afull,
    output src0_rd_en, src1_rd_en, tx_wr_en, tx_wr_data, grant, frame_cnt, trunc_cnt
  );

  modport slave (
    output src0_dout, src1_dout, src0_empty, src1_empty, tx_afull,
    input  src0_rd_en, src1_rd_en, tx_wr_en, tx_wr_data, grant, frame_cnt, trunc_cnt
  );
endinterface

// File: rtl/tx_arbiter.sv
// Two-source frame arbiter: forwards whole frames from two FWFT sources into
// one tx write port, appends a 9'h000 terminator and enforces an inter-frame gap.
module tx_arbiter #(
  parameter int MAX_WORDS  = 1522,
  parameter int IFG_CYCLES = 12
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  tx_arbiter_if.master bus
);

  localparam int CW = ($clog2(MAX_WORDS + 1) > 11) ? $clog2(MAX_WORDS + 1) : 11;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
  // GAP always occupies at least one cycle, so IFG_CYCLES=0 and 1 behave alike.
  localparam logic [15:0] GAP_LAST = (IFG_CYCLES > 1) ? 16'(IFG_CYCLES - 1) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_TERM  = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e      state_q;
  logic        grant_q;
  logic [CW-1:0] cnt_q;
  logic        trunc_q;
  logic [15:0] gap_q;
  logic        wr_en_q;
  logic [8:0]  wr_data_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] trunc_cnt_q;

  logic [8:0]  g_dout;
  logic        g_empty;
  logic        cand0;
  logic        cand1;
  logic        at_max;
  logic        pop_g;
  logic        rd0_d;
  logic        rd1_d;

  always_comb begin
    g_dout  = grant_q ? bus.src1_dout  : bus.src0_dout;
    g_empty = grant_q ? bus.src1_empty : bus.src0_empty;
    cand0   = !bus.src0_empty && bus.src0_dout[8];
    cand1   = !bus.src1_empty && bus.src1_dout[8];
    at_max  = (cnt_q == MAX_CNT);
    pop_g   = 1'b0;
    rd0_d   = 1'b0;
    rd1_d   = 1'b0;
    case (state_q)
      // Stray end markers are flushed from either source while waiting.
      S_IDLE: begin
        rd0_d = !bus.src0_empty && !bus.src0_dout[8];
        rd1_d = !bus.src1_empty && !bus.src1_dout[8];
      end
      S_SEND: begin
        pop_g = !g_empty && !bus.tx_afull && !(g_dout[8] && at_max);
        rd0_d = pop_g && !grant_q;
        rd1_d = pop_g && grant_q;
      end
      S_DRAIN: begin
        pop_g = !g_empty;
        rd0_d = pop_g && !grant_q;
        rd1_d = pop_g && grant_q;
      end
      default: begin
        pop_g = 1'b0;
      end
    endcase
    if (sys_rst) begin
      rd0_d = 1'b0;
      rd1_d = 1'b0;
    end else begin
      rd0_d = rd0_d;
      rd1_d = rd1_d;
    end
  end

  assign bus.src0_rd_en = rd0_d;
  assign bus.src1_rd_en = rd1_d;
  assign bus.tx_wr_en   = wr_en_q;
  assign bus.tx_wr_data = wr_data_q;
  assign bus.grant      = grant_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.trunc_cnt  = trunc_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b1;
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
      gap_q       <= 16'd0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 9'h000;
      frame_cnt_q <= 16'd0;
      trunc_cnt_q <= 16'd0;
    end else begin
      wr_en_q   <= 1'b0;
      wr_data_q <= 9'h000;
      case (state_q)
        S_IDLE: begin
          if (cand0 || cand1) begin
            grant_q <= (cand0 && cand1) ? ~grant_q : cand1;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (pop_g) begin
            if (g_dout[8]) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= g_dout;
              cnt_q     <= cnt_q + CW'(1);
            end else begin
              state_q <= S_TERM;
            end
          end else if (!g_empty && g_dout[8] && at_max) begin
            // Over-length frame: leave the word in the source; DRAIN discards it.
            trunc_q <= 1'b1;
            state_q <= S_TERM;
          end
        end
        S_TERM: begin
          if (!bus.tx_afull) begin
            wr_en_q     <= 1'b1;
            wr_data_q   <= 9'h000;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (trunc_q) begin
              trunc_cnt_q <= trunc_cnt_q + 16'd1;
              state_q     <= S_DRAIN;
            end else begin
              gap_q   <= 16'd0;
              state_q <= S_GAP;
            end
          end
        end
        S_DRAIN: begin
          if (pop_g && !g_dout[8]) begin
            gap_q   <= 16'd0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q >= GAP_LAST) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a cycle table for the IDLE/SEND/TERM basics,
// then queue-modelled FWFT sources for multi-cycle frame scenarios.
module tb_tx_arbiter;

  logic clk;
  logic sys_rst;
  tx_arbiter_if bus ();

  tx_arbiter #(.MAX_WORDS(64), .IFG_CYCLES(12)) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s0_v;
    logic [8:0] s0_d;
    logic       s1_v;
    logic [8:0] s1_d;
    logic       afull;
    logic       rd0;
    logic       rd1;
    logic       wr_en;
    logic [8:0] wr_data;
    logic       grant;
    logic [15:0] fcnt;
  } vec_t;

  vec_t vecs [10];

  int n_cmp = 0;
  int n_fail = 0;
  int bad_idle_data = 0;
  bit model_en = 1'b0;
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];
  logic last_pop0, last_pop1, last_rd0, last_rd1, last_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_srcs();
    bus.src0_empty = (q0.size() == 0);
    bus.src0_dout  = (q0.size() == 0) ? 9'h000 : q0[0];
    bus.src1_empty = (q1.size() == 0);
    bus.src1_dout  = (q1.size() == 0) ? 9'h000 : q1[0];
  endtask

  // One clock: sample at negedge, then apply source pops just after posedge.
  task automatic tick();
    logic rst_seen;
    @(negedge clk);
    last_rd0  = bus.src0_rd_en;
    last_rd1  = bus.src1_rd_en;
    last_pop0 = bus.src0_rd_en && !bus.src0_empty;
    last_pop1 = bus.src1_rd_en && !bus.src1_empty;
    last_wr   = bus.tx_wr_en;
    if (bus.tx_wr_en) got_q.push_back(bus.tx_wr_data);
    else if (bus.tx_wr_data !== 9'h000) bad_idle_data++;
    rst_seen = sys_rst;
    @(posedge clk);
    #1;
    if (model_en) begin
      if (rst_seen) begin
        q0.delete();
        q1.delete();
      end else begin
        if (last_pop0) q0.delete(0);
        if (last_pop1) q1.delete(0);
      end
      drive_srcs();
    end
  endtask

  task automatic do_reset();
    model_en = 1'b1;
    q0.delete();
    q1.delete();
    drive_srcs();
    bus.tx_afull = 1'b0;
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk({name, "_timeout"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic check_seq(input string name);
    chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    //              s0_v  s0_d    s1_v  s1_d    af    rd0   rd1   wr    wdata   g     fcnt
    vecs[0] = '{1'b1, 9'h055, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 16'd0};
    vecs[1] = '{1'b1, 9'h111, 1'b1, 9'h022, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 16'd0};
    vecs[2] = '{1'b1, 9'h111, 1'b1, 9'h133, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 9'h112, 1'b1, 9'h133, 1'b1, 1'b0, 1'b0, 1'b1, 9'h111, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 9'h112, 1'b1, 9'h133, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 16'd0};
    vecs[5] = '{1'b0, 9'h000, 1'b1, 9'h133, 1'b0, 1'b0, 1'b0, 1'b1, 9'h112, 1'b0, 16'd0};
    vecs[6] = '{1'b1, 9'h000, 1'b1, 9'h133, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 16'd0};
    vecs[7] = '{1'b1, 9'h144, 1'b1, 9'h133, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 16'd0};
    vecs[8] = '{1'b1, 9'h144, 1'b1, 9'h133, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 16'd0};
    vecs[9] = '{1'b1, 9'h144, 1'b1, 9'h133, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 16'd1};

    // Reset with a stray marker present: rd_en must stay low while reset is high.
    model_en = 1'b0;
    sys_rst = 1'b1;
    bus.tx_afull = 1'b0;
    bus.src0_empty = 1'b0;
    bus.src0_dout  = 9'h055;
    bus.src1_empty = 1'b1;
    bus.src1_dout  = 9'h000;
    tick();
    chk("rst_rd0", 32'(last_rd0), 32'd0);
    tick();
    chk("rst_rd0_b", 32'(last_rd0), 32'd0);
    sys_rst = 1'b0;
    chk("rst_wr_en", 32'(bus.tx_wr_en), 32'd0);
    chk("rst_wr_data", 32'(bus.tx_wr_data), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd1);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_trunc_cnt", 32'(bus.trunc_cnt), 32'd0);

    for (int i = 0; i < 10; i++) begin
      bus.src0_empty = !vecs[i].s0_v;
      bus.src0_dout  = vecs[i].s0_d;
      bus.src1_empty = !vecs[i].s1_v;
      bus.src1_dout  = vecs[i].s1_d;
      bus.tx_afull   = vecs[i].afull;
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", i), 32'(bus.src0_rd_en), 32'(vecs[i].rd0));
      chk($sformatf("vec%0d_rd1", i), 32'(bus.src1_rd_en), 32'(vecs[i].rd1));
      chk($sformatf("vec%0d_wr_en", i), 32'(bus.tx_wr_en), 32'(vecs[i].wr_en));
      chk($sformatf("vec%0d_wr_data", i), 32'(bus.tx_wr_data), 32'(vecs[i].wr_data));
      chk($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vecs[i].grant));
      chk($sformatf("vec%0d_fcnt", i), 32'(bus.frame_cnt), 32'(vecs[i].fcnt));
      @(posedge clk);
      #1;
    end

    // GAP: vecs[9] was gap cycle 1 of 12; 11 more silent cycles, then IDLE tie.
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("gap%0d_quiet", i), 32'({last_rd0, last_rd1, last_wr}), 32'd0);
    end
    tick();
    chk("idle_tie_no_pop", 32'({last_rd0, last_rd1}), 32'd0);
    chk("idle_tie_grant_rr", 32'(bus.grant), 32'd1);
    tick();
    chk("send_src1_pop", 32'({last_rd0, last_rd1}), 32'd1);

    // Single 60-byte frame on src0, then a queued 3-byte frame held off by the gap.
    do_reset();
    for (int i = 0; i < 60; i++) q0.push_back({1'b1, 8'(i)});
    q0.push_back(9'h000);
    q0.push_back(9'h1C0); q0.push_back(9'h1C1); q0.push_back(9'h1C2); q0.push_back(9'h000);
    drive_srcs();
    for (int i = 0; i < 60; i++) exp_q.push_back({1'b1, 8'(i)});
    exp_q.push_back(9'h000);
    run_until(61, 400, "f60");
    chk("f60_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("f60_ifg%0d", i), 32'({last_pop0, last_pop1, last_wr}), 32'd0);
    end
    exp_q.push_back(9'h1C0); exp_q.push_back(9'h1C1); exp_q.push_back(9'h1C2); exp_q.push_back(9'h000);
    run_until(65, 100, "f60b");
    check_seq("f60");
    chk("f60b_frame_cnt", 32'(bus.frame_cnt), 32'd2);
    chk("f60b_grant", 32'(bus.grant), 32'd0);

    // Simultaneous start after reset: src0 first, then src1, then src0 wins next tie.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      q0.push_back(9'h1A0); q0.push_back(9'h1A1); q0.push_back(9'h1A2); q0.push_back(9'h1A3);
      q0.push_back(9'h000);
      q1.push_back(9'h1B0); q1.push_back(9'h1B1); q1.push_back(9'h1B2); q1.push_back(9'h000);
      drive_srcs();
      exp_q.push_back(9'h1A0); exp_q.push_back(9'h1A1); exp_q.push_back(9'h1A2);
      exp_q.push_back(9'h1A3); exp_q.push_back(9'h000);
      exp_q.push_back(9'h1B0); exp_q.push_back(9'h1B1); exp_q.push_back(9'h1B2);
      exp_q.push_back(9'h000);
      run_until(9 * (r + 1), 200, "tie");
    end
    check_seq("tie");
    chk("tie_frame_cnt", 32'(bus.frame_cnt), 32'd4);

    // Back-pressure held for 5 cycles mid-frame.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      q0.push_back({1'b1, 8'(8'h40 + 8'(i))});
      exp_q.push_back({1'b1, 8'(8'h40 + 8'(i))});
    end
    q0.push_back(9'h000);
    exp_q.push_back(9'h000);
    drive_srcs();
    run_until(4, 100, "afull_pre");
    bus.tx_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("afull%0d_no_pop", i), 32'(last_pop0), 32'd0);
      if (i > 0) chk($sformatf("afull%0d_no_wr", i), 32'(last_wr), 32'd0);
    end
    bus.tx_afull = 1'b0;
    run_until(21, 200, "afull");
    check_seq("afull");

    // 100-byte src1 frame truncated at 64; drain ignores tx_afull.
    do_reset();
    for (int i = 0; i < 100; i++) q1.push_back({1'b1, 8'(i)});
    q1.push_back(9'h000);
    drive_srcs();
    for (int i = 0; i < 64; i++) exp_q.push_back({1'b1, 8'(i)});
    exp_q.push_back(9'h000);
    run_until(65, 400, "trunc");
    bus.tx_afull = 1'b1;
    for (int c = 0; c < 200 && q1.size() > 0; c++) tick();
    bus.tx_afull = 1'b0;
    repeat (3) tick();
    chk("trunc_drained", 32'(q1.size()), 32'd0);
    check_seq("trunc");
    chk("trunc_cnt", 32'(bus.trunc_cnt), 32'd1);
    chk("trunc_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    chk("trunc_grant", 32'(bus.grant), 32'd1);

    // Reset after 10 words: no terminator, counters cleared, new frame accepted.
    do_reset();
    for (int i = 0; i < 30; i++) q0.push_back({1'b1, 8'(i)});
    q0.push_back(9'h000);
    drive_srcs();
    run_until(10, 100, "mrst_pre");
    sys_rst = 1'b1;
    tick();
    chk("mrst_rd_low", 32'({last_rd0, last_rd1}), 32'd0);
    sys_rst = 1'b0;
    chk("mrst_wr_en", 32'(bus.tx_wr_en), 32'd0);
    chk("mrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    got_q.delete();
    repeat (20) tick();
    chk("mrst_no_term", 32'(got_q.size()), 32'd0);
    q1.push_back(9'h1D0); q1.push_back(9'h1D1); q1.push_back(9'h000);
    drive_srcs();
    exp_q.delete();
    exp_q.push_back(9'h1D0); exp_q.push_back(9'h1D1); exp_q.push_back(9'h000);
    run_until(3, 100, "mrst_post");
    check_seq("mrst_post");
    chk("mrst_post_frame_cnt", 32'(bus.frame_cnt), 32'd1);

    chk("idle_data_zero", 32'(bad_idle_data), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
